mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single-port-per-cycle `mem` block.
- Accepts read/write requests over valid/ready handshakes.
- Drives exactly one memory command per cycle, never rd_en and wr_en together, because `mem` ignores that combination.
- Returns an in-order response, with data on reads, to the requester that issued the command.
- Rejects out-of-range addresses without touching memory.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle for the two requesters plus the memory command bus of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_ADR    = 100,
  parameter int unsigned ADDRSIZE   = $clog2(MAX_ADR)
);
  logic                  p0_req_valid;
  logic                  p0_req_ready;
  logic                  p0_req_we;
  logic [ADDRSIZE-1:0]   p0_req_addr;
  logic [DATA_WIDTH-1:0] p0_req_wdata;
  logic                  p0_rsp_valid;
  logic                  p0_rsp_err;
  logic [DATA_WIDTH-1:0] p0_rsp_data;

  logic                  p1_req_valid;
  logic                  p1_req_ready;
  logic                  p1_req_we;
  logic [ADDRSIZE-1:0]   p1_req_addr;
  logic [DATA_WIDTH-1:0] p1_req_wdata;
  logic                  p1_rsp_valid;
  logic                  p1_rsp_err;
  logic [DATA_WIDTH-1:0] p1_rsp_data;

  logic                  mem_rd_en;
  logic [ADDRSIZE-1:0]   mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr_en;
  logic [ADDRSIZE-1:0]   mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_data,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_data,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_data,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_data,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// A two-stage pipeline gives a fixed 2-cycle, in-order response.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_ADR    = 100,
  parameter int unsigned ADDRSIZE   = $clog2(MAX_ADR)
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  logic                  last_grant_q;
  logic                  gnt0, gnt1, accept;
  logic                  sel_we, sel_err;
  logic [ADDRSIZE-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  s1_valid_q, s1_port_q, s1_we_q, s1_err_q;
  logic [ADDRSIZE-1:0]   s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_wdata_q;
  logic                  s2_valid_q, s2_port_q, s2_we_q, s2_err_q;

  logic                  rd_hit, wr_hit;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Grants are forced low during reset, so every output reads 0 while rst is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req_valid && (!bus.p1_req_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (bus.p1_req_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept    = gnt0 | gnt1;
  assign sel_we    = gnt1 ? bus.p1_req_we    : bus.p0_req_we;
  assign sel_addr  = gnt1 ? bus.p1_req_addr  : bus.p0_req_addr;
  assign sel_wdata = gnt1 ? bus.p1_req_wdata : bus.p0_req_wdata;
  assign sel_err   = 32'(sel_addr) >= MAX_ADR;

  assign bus.p0_req_ready = gnt0;
  assign bus.p1_req_ready = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_port_q    <= 1'b0;
      s1_we_q      <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_addr_q    <= '0;
      s1_wdata_q   <= '0;
      s2_valid_q   <= 1'b0;
      s2_port_q    <= 1'b0;
      s2_we_q      <= 1'b0;
      s2_err_q     <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_q <= gnt1;
      end
      s1_valid_q <= accept;
      s1_port_q  <= gnt1;
      s1_we_q    <= sel_we;
      s1_err_q   <= sel_err;
      s1_addr_q  <= sel_addr;
      s1_wdata_q <= sel_wdata;
      s2_valid_q <= s1_valid_q;
      s2_port_q  <= s1_port_q;
      s2_we_q    <= s1_we_q;
      s2_err_q   <= s1_err_q;
    end
  end

  // Out-of-range commands never reach memory; they only carry the error flag forward.
  assign rd_hit = s1_valid_q & ~s1_we_q & ~s1_err_q;
  assign wr_hit = s1_valid_q &  s1_we_q & ~s1_err_q;

  assign bus.mem_rd_en   = rd_hit;
  assign bus.mem_rd_addr = rd_hit ? s1_addr_q : '0;
  assign bus.mem_wr_en   = wr_hit;
  assign bus.mem_wr_addr = wr_hit ? s1_addr_q : '0;
  assign bus.mem_wr_data = wr_hit ? s1_wdata_q : '0;

  assign rsp_data = (s2_valid_q && !s2_we_q && !s2_err_q) ? bus.mem_rd_data : '0;

  assign bus.p0_rsp_valid = s2_valid_q & ~s2_port_q;
  assign bus.p0_rsp_err   = s2_valid_q & ~s2_port_q & s2_err_q;
  assign bus.p0_rsp_data  = s2_port_q ? '0 : rsp_data;
  assign bus.p1_rsp_valid = s2_valid_q & s2_port_q;
  assign bus.p1_rsp_err   = s2_valid_q & s2_port_q & s2_err_q;
  assign bus.p1_rsp_data  = s2_port_q ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference arbiter and shadow memory predict every grant,
// memory command and response. A behavioural registered-read memory sits on the mem bus.
module tb_mem_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned MA = 100;
  localparam int unsigned AW = $clog2(MA);

  typedef struct {
    bit          port;
    bit          we;
    bit          err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
    int          due;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   lg = 1'b1;
  txn_t q[$];

  logic [DW-1:0] mem_arr [MA];
  logic [DW-1:0] shadow  [MA];
  logic [DW-1:0] rd_q;

  mem_arbiter_if #(.DATA_WIDTH(DW), .MAX_ADR(MA)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_ADR(MA)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_wr_en && 32'(bus.mem_wr_addr) < MA) mem_arr[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) rd_q <= (32'(bus.mem_rd_addr) < MA) ? mem_arr[bus.mem_rd_addr] : 8'hxx;
  end
  assign bus.mem_rd_data = rd_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    txn_t e;
    bit e0, e1;
    if (rst) begin
      check("rst_outs", {bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p0_rsp_err,
                         bus.p0_rsp_data, bus.p1_rsp_valid, bus.p1_rsp_err, bus.p1_rsp_data,
                         bus.mem_rd_en, bus.mem_rd_addr, bus.mem_wr_en, bus.mem_wr_addr,
                         bus.mem_wr_data}, 64'd0);
      q.delete();
      lg = 1'b1;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("rsp_valid0", bus.p0_rsp_valid, !e.port);
        check("rsp_valid1", bus.p1_rsp_valid, e.port);
        check("rsp_err", e.port ? bus.p1_rsp_err : bus.p0_rsp_err, e.err);
        check("rsp_data", e.port ? bus.p1_rsp_data : bus.p0_rsp_data, e.data);
      end else begin
        check("rsp_idle", {bus.p0_rsp_valid, bus.p1_rsp_valid}, 0);
      end

      if (q.size() > 0 && q[0].due == cyc + 1) begin
        check("s1_rd_en", bus.mem_rd_en, !q[0].we && !q[0].err);
        check("s1_wr_en", bus.mem_wr_en, q[0].we && !q[0].err);
        if (!q[0].err && !q[0].we) check("s1_rd_addr", bus.mem_rd_addr, q[0].addr);
        if (!q[0].err && q[0].we) begin
          check("s1_wr_addr", bus.mem_wr_addr, q[0].addr);
          check("s1_wr_data", bus.mem_wr_data, q[0].wdata);
        end
      end else begin
        check("s1_idle", {bus.mem_rd_en, bus.mem_wr_en}, 0);
      end

      e0 = bus.p0_req_valid && (!bus.p1_req_valid || lg);
      e1 = bus.p1_req_valid && !e0;
      check("ready0", bus.p0_req_ready, e0);
      check("ready1", bus.p1_req_ready, e1);
      if (e0 || e1) begin
        e.port  = e1;
        e.we    = e1 ? bus.p1_req_we : bus.p0_req_we;
        e.addr  = e1 ? bus.p1_req_addr : bus.p0_req_addr;
        e.wdata = e1 ? bus.p1_req_wdata : bus.p0_req_wdata;
        e.err   = 32'(e.addr) >= MA;
        e.due   = cyc + 2;
        e.data  = '0;
        if (!e.err && e.we) shadow[e.addr] = e.wdata;
        else if (!e.err) e.data = shadow[e.addr];
        q.push_back(e);
        lg = e1;
      end
    end
  end

  task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit v1, input bit we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.p0_req_valid = v0; bus.p0_req_we = we0; bus.p0_req_addr = a0; bus.p0_req_wdata = d0;
    bus.p1_req_valid = v1; bus.p1_req_we = we1; bus.p1_req_addr = a1; bus.p1_req_wdata = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(MA); i++) begin
      mem_arr[i] = '0;
      shadow[i]  = '0;
    end
    mem_arr[1] = 8'h11; shadow[1] = 8'h11;
    mem_arr[2] = 8'h22; shadow[2] = 8'h22;
    rd_q = '0;
    bus.p0_req_valid = 0; bus.p0_req_we = 0; bus.p0_req_addr = '0; bus.p0_req_wdata = '0;
    bus.p1_req_valid = 0; bus.p1_req_we = 0; bus.p1_req_addr = '0; bus.p1_req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // p0 write then immediate read-back of address 5
    drive(1, 1, 7'd5, 8'hA5, 0, 0, 0, 0);
    drive(1, 0, 7'd5, 8'h00, 0, 0, 0, 0);
    idle(3);

    // Fresh pointer so p0 wins the first contention; four cycles of held contention
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 7'd1, 0, 1, 0, 7'd2, 0);
    idle(3);

    // Out-of-range read on p1
    drive(0, 0, 0, 0, 1, 0, 7'd120, 0);
    idle(3);

    // Write on p0 followed next cycle by read of the same address on p1
    drive(1, 1, 7'd7, 8'h3C, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 7'd7, 0);
    idle(3);

    // Make p0 the last grant, then reset with a p0 read in stage 1
    drive(1, 0, 7'd3, 0, 0, 0, 0, 0);
    bus.p0_req_valid = 0;
    rst = 1'b1;
    #1;
    check("rst_rd_en_now", bus.mem_rd_en, 1'b0);
    check("rst_ready_now", {bus.p0_req_ready, bus.p1_req_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    bus.p0_req_valid = 1; bus.p0_req_we = 0; bus.p0_req_addr = 7'd1;
    bus.p1_req_valid = 1; bus.p1_req_we = 0; bus.p1_req_addr = 7'd2;
    #1;
    check("post_rst_grant_p0", {bus.p0_req_ready, bus.p1_req_ready}, 2'b10);
    drive(1, 0, 7'd1, 0, 1, 0, 7'd2, 0);
    idle(3);

    // Random traffic including out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 7'($urandom_range(0, 110)),
            8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
            7'($urandom_range(0, 110)), 8'($urandom));
    end
    idle(4);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
